// File: rtl/microsequencer_pkg.sv
// Shared definitions for the ARC control-store sequencer: microword field
// positions, branch-condition codes, FSM state encoding and reset address.
package microsequencer_pkg;

  localparam int DATAWIDTH_BUS_ADDRESS = 11;
  localparam int DATAWIDTH_BUS_WORD    = 41;
  localparam int DATAWIDTH_BUS_IR      = 32;

  // Microword field bit positions (bit 40 is the MSB).
  localparam int A_MSB      = 40;
  localparam int A_LSB      = 35;
  localparam int AMUX_BIT   = 34;
  localparam int B_MSB      = 33;
  localparam int B_LSB      = 28;
  localparam int BMUX_BIT   = 27;
  localparam int C_MSB      = 26;
  localparam int C_LSB      = 21;
  localparam int CMUX_BIT   = 20;
  localparam int RD_BIT     = 19;
  localparam int WR_BIT     = 18;
  localparam int ALU_MSB    = 17;
  localparam int ALU_LSB    = 14;
  localparam int COND_MSB   = 13;
  localparam int COND_LSB   = 11;
  localparam int JADDR_MSB  = 10;
  localparam int JADDR_LSB  = 0;

  // PSR_NZVC bit positions, {N,Z,V,C}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // IR bit that selects the immediate form; tested by COND_IR13.
  localparam int IR_I_BIT = 13;

  // Branch condition codes carried in the COND field.
  typedef enum logic [2:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;

  // Microcycle phases.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [DATAWIDTH_BUS_ADDRESS-1:0] RESET_ADDR = '0;

  // Instruction decode target: {1, op, op3, 00}. Each instruction gets a
  // four-word slot in the upper half of the control store.
  function automatic logic [DATAWIDTH_BUS_ADDRESS-1:0] decode_addr(
    input logic [DATAWIDTH_BUS_IR-1:0] ir
  );
    return {1'b1, ir[31:30], ir[24:19], 2'b00};
  endfunction

endpackage

// File: rtl/microsequencer_cbl.sv
// Control branch logic: purely combinational next-address selection from the
// microword COND/JUMP_ADDR fields, the current address, the flags and the IR.
module microsequencer_cbl
  import microsequencer_pkg::*;
(
  input  logic [2:0]                       i_cond,
  input  logic [DATAWIDTH_BUS_ADDRESS-1:0] i_jump_addr,
  input  logic [DATAWIDTH_BUS_ADDRESS-1:0] i_address,
  input  logic [3:0]                       i_psr_nzvc,
  input  logic [DATAWIDTH_BUS_IR-1:0]      i_ir,
  output logic [DATAWIDTH_BUS_ADDRESS-1:0] o_next_addr
);

  logic [DATAWIDTH_BUS_ADDRESS-1:0] w_seq_addr;
  logic                             w_take;
  cond_e                            w_cond;
  logic                             w_unused_ir;

  // Sequential successor; the 11-bit add wraps 2047 -> 0 silently.
  assign w_seq_addr = i_address + 11'd1;
  assign w_cond     = cond_e'(i_cond);

  // Only op, op3 and the i bit steer sequencing; the rest of the IR is data.
  assign w_unused_ir = ^{i_ir[29:25], i_ir[18:14], i_ir[12:0]};

  // Evaluate the branch condition selected by COND.
  always_comb begin
    w_take = 1'b0;
    case (w_cond)
      COND_NEXT:   w_take = 1'b0;
      COND_N:      w_take = i_psr_nzvc[FLAG_N];
      COND_Z:      w_take = i_psr_nzvc[FLAG_Z];
      COND_V:      w_take = i_psr_nzvc[FLAG_V];
      COND_C:      w_take = i_psr_nzvc[FLAG_C];
      COND_IR13:   w_take = i_ir[IR_I_BIT];
      COND_JUMP:   w_take = 1'b1;
      COND_DECODE: w_take = 1'b0;
      default:     w_take = 1'b0;
    endcase
  end

  // Pick the next address: decode target, jump target or sequential.
  always_comb begin
    o_next_addr = w_seq_addr;
    if (w_cond == COND_DECODE) begin
      o_next_addr = decode_addr(i_ir);
    end else if (w_take) begin
      o_next_addr = i_jump_addr;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Control-store address sequencer. Runs a FETCH/EXEC microcycle, stretches
// EXEC into WAIT cycles while a memory access is outstanding, and strobes the
// datapath in the one cycle the current microword commits.
//
// Handshake: a microword with RD or WR set requests memory; MEM_ACK is the
// completion and is sampled only in EXEC (for such a word) and in WAIT. The
// access completes in the first such cycle with MEM_ACK=1, which is also the
// cycle EXEC_STROBE is high and ADDRESS loads at the closing edge. RD and WR
// together form one access needing one MEM_ACK.
module microsequencer
  import microsequencer_pkg::*;
(
  input  logic                             CLK,
  input  logic                             RESET_InLow,
  input  logic [DATAWIDTH_BUS_WORD-1:0]    MIR_WORD,
  input  logic [DATAWIDTH_BUS_IR-1:0]      IR,
  input  logic [3:0]                       PSR_NZVC,
  input  logic                             MEM_ACK,
  output logic [DATAWIDTH_BUS_ADDRESS-1:0] ADDRESS,
  output logic                             EXEC_STROBE,
  output logic                             MEM_WAIT,
  output logic [1:0]                       o_dbg_state
);

  state_e                           r_state;
  state_e                           w_state_next;
  logic                             w_load;
  logic                             w_mem_access;
  logic [DATAWIDTH_BUS_ADDRESS-1:0] w_next_addr;
  logic                             w_unused_mir;

  // Datapath-control fields of the microword are not used for sequencing.
  assign w_unused_mir = ^{MIR_WORD[A_MSB:CMUX_BIT], MIR_WORD[ALU_MSB:ALU_LSB]};

  assign w_mem_access = MIR_WORD[RD_BIT] | MIR_WORD[WR_BIT];

  microsequencer_cbl u_cbl (
    .i_cond      (MIR_WORD[COND_MSB:COND_LSB]),
    .i_jump_addr (MIR_WORD[JADDR_MSB:JADDR_LSB]),
    .i_address   (ADDRESS),
    .i_psr_nzvc  (PSR_NZVC),
    .i_ir        (IR),
    .o_next_addr (w_next_addr)
  );

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge CLK or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and the commit decision for the current microword.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      FETCH: begin
        w_state_next = EXEC;
      end
      EXEC: begin
        if (w_mem_access && !MEM_ACK) begin
          w_state_next = WAIT;
        end else begin
          w_load       = 1'b1;
          w_state_next = FETCH;
        end
      end
      WAIT: begin
        if (MEM_ACK) begin
          w_load       = 1'b1;
          w_state_next = FETCH;
        end
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  // Address register loads only when the microword commits.
  always_ff @(posedge CLK or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      ADDRESS <= RESET_ADDR;
    end else if (w_load) begin
      ADDRESS <= w_next_addr;
    end
  end

  // Registered stall indicator: high exactly while in WAIT.
  always_ff @(posedge CLK or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      MEM_WAIT <= 1'b0;
    end else begin
      MEM_WAIT <= (w_state_next == WAIT);
    end
  end

  assign EXEC_STROBE = w_load;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed branch/decode/stall/wrap
// cases followed by random microinstructions against a per-instruction model.
module tb_microsequencer;

  logic        CLK;
  logic        RESET_InLow;
  logic [40:0] MIR_WORD;
  logic [31:0] IR;
  logic [3:0]  PSR_NZVC;
  logic        MEM_ACK;
  logic [10:0] ADDRESS;
  logic        EXEC_STROBE;
  logic        MEM_WAIT;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int m_addr   = 0;
  logic [10:0] exp_q[$];

  microsequencer dut (
    .CLK         (CLK),
    .RESET_InLow (RESET_InLow),
    .MIR_WORD    (MIR_WORD),
    .IR          (IR),
    .PSR_NZVC    (PSR_NZVC),
    .MEM_ACK     (MEM_ACK),
    .ADDRESS     (ADDRESS),
    .EXEC_STROBE (EXEC_STROBE),
    .MEM_WAIT    (MEM_WAIT),
    .o_dbg_state (o_dbg_state)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Safety timeout
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: next address from the COND table with plain arithmetic.
  function automatic int model_next(input int addr, input logic [40:0] w,
                                    input logic [31:0] ir, input logic [3:0] f);
    int cond;
    int ja;
    int seq;
    cond = int'(w[13:11]);
    ja   = int'(w[10:0]);
    seq  = (addr + 1) % 2048;
    case (cond)
      0: return seq;
      1: return f[3] ? ja : seq;
      2: return f[2] ? ja : seq;
      3: return f[1] ? ja : seq;
      4: return f[0] ? ja : seq;
      5: return ir[13] ? ja : seq;
      6: return ja;
      default: return 1024 + int'(ir[31:30]) * 256 + int'(ir[24:19]) * 4;
    endcase
  endfunction

  function automatic logic [40:0] mk_word(input bit rd, input bit wr,
                                          input int cond, input int ja);
    logic [40:0] w;
    w = {$urandom, $urandom};
    w[19] = rd;
    w[18] = wr;
    w[13:11] = 3'(cond);
    w[10:0] = 11'(ja);
    return w;
  endfunction

  // Reset held for three cycles; released just after a rising edge so the
  // following cycle is FETCH.
  task automatic do_reset();
    RESET_InLow = 1'b0;
    MEM_ACK = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_addr", 32'(ADDRESS), 0);
    check("reset_strobe", 32'(EXEC_STROBE), 0);
    check("reset_memwait", 32'(MEM_WAIT), 0);
    RESET_InLow = 1'b1;
    m_addr = 0;
    exp_q.delete();
    exp_q.push_back(11'd0);
  endtask

  // One full microinstruction, entered at the start of its FETCH cycle.
  task automatic run_uinstr(input logic [40:0] word, input logic [31:0] ir,
                            input logic [3:0] f, input int stalls, input bit rerand);
    bit mem;
    int nxt;
    logic [10:0] exp_a;
    mem = word[19] | word[18];
    // FETCH: microword not yet latched, MEM_ACK must be ignored
    MIR_WORD = {$urandom, $urandom};
    MEM_ACK = 1'($urandom);
    #1;
    exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : 11'(m_addr);
    check("fetch_addr", 32'(ADDRESS), 32'(exp_a));
    check("fetch_strobe", 32'(EXEC_STROBE), 0);
    check("fetch_memwait", 32'(MEM_WAIT), 0);
    @(posedge CLK); #1;
    // EXEC
    MIR_WORD = word;
    IR = ir;
    PSR_NZVC = f;
    MEM_ACK = mem ? (stalls == 0) : 1'($urandom);
    #1;
    check("exec_addr_held", 32'(ADDRESS), 32'(m_addr));
    check("exec_memwait", 32'(MEM_WAIT), 0);
    check("exec_strobe", 32'(EXEC_STROBE), 32'(!mem || stalls == 0));
    if (mem) begin
      for (int j = 1; j <= stalls; j++) begin
        @(posedge CLK); #1;
        MEM_ACK = (j == stalls);
        if (j == stalls && rerand) begin
          IR = $urandom;
          PSR_NZVC = 4'($urandom);
        end
        #1;
        check("wait_memwait", 32'(MEM_WAIT), 1);
        check("wait_addr_held", 32'(ADDRESS), 32'(m_addr));
        check("wait_strobe", 32'(EXEC_STROBE), 32'(j == stalls));
      end
    end
    // Next address uses the IR/flags present in the load cycle.
    nxt = model_next(m_addr, word, IR, PSR_NZVC);
    @(posedge CLK); #1;
    m_addr = nxt;
    exp_q.push_back(11'(nxt));
  endtask

  initial begin
    logic [31:0] ir_v;
    int st;
    RESET_InLow = 1'b0;
    MIR_WORD = '0;
    IR = '0;
    PSR_NZVC = '0;
    MEM_ACK = 1'b0;
    #2;
    do_reset();

    // Branch on Z from address 8 to 12, and fall-through to 9
    run_uinstr(mk_word(0, 0, 6, 8), $urandom, 4'($urandom), 0, 0);
    run_uinstr(mk_word(0, 0, 2, 12), $urandom, 4'b0100, 0, 0);
    run_uinstr(mk_word(0, 0, 6, 8), $urandom, 4'($urandom), 0, 0);
    run_uinstr(mk_word(0, 0, 2, 12), $urandom, 4'b1011, 0, 0);
    // IR[13] branch
    ir_v = $urandom; ir_v[13] = 1'b1;
    run_uinstr(mk_word(0, 0, 5, 300), ir_v, 4'($urandom), 0, 0);
    ir_v[13] = 1'b0;
    run_uinstr(mk_word(0, 0, 5, 700), ir_v, 4'($urandom), 0, 0);
    // Decode ADDCC: op=10, op3=010000 -> 1600
    ir_v = $urandom; ir_v[31:30] = 2'b10; ir_v[24:19] = 6'b010000;
    run_uinstr(mk_word(0, 0, 7, $urandom_range(0, 2047)), ir_v, 4'($urandom), 0, 0);
    #1;
    check("decode_1600", 32'(ADDRESS), 1600);
    // Memory read with three stall cycles
    run_uinstr(mk_word(1, 0, 0, 0), $urandom, 4'($urandom), 3, 0);
    // Read and write together: one ack
    run_uinstr(mk_word(1, 1, 6, 2047), $urandom, 4'($urandom), 1, 0);
    // Wrap-around 2047 -> 0
    run_uinstr(mk_word(0, 0, 0, $urandom_range(0, 2047)), $urandom, 4'($urandom), 0, 0);
    #1;
    check("wrap_to_zero", 32'(ADDRESS), 0);

    // Random microinstructions
    for (int i = 0; i < 60; i++) begin
      st = $urandom_range(0, 3);
      run_uinstr(mk_word(1'($urandom), 1'($urandom), $urandom_range(0, 7),
                         $urandom_range(0, 2047)),
                 $urandom, 4'($urandom), st, 1);
    end

    // Reset during WAIT: jump away from 0, then stall and reset mid-cycle
    run_uinstr(mk_word(0, 0, 6, 555), $urandom, 4'($urandom), 0, 0);
    MIR_WORD = {$urandom, $urandom};
    #1;
    void'(exp_q.pop_front());
    @(posedge CLK); #1;
    MIR_WORD = mk_word(1, 0, 6, 99);
    MEM_ACK = 1'b0;
    @(posedge CLK); #1;
    check("pre_reset_memwait", 32'(MEM_WAIT), 1);
    check("pre_reset_addr", 32'(ADDRESS), 555);
    MEM_ACK = 1'b1;
    #1;
    RESET_InLow = 1'b0;
    #1;
    check("async_reset_addr", 32'(ADDRESS), 0);
    check("async_reset_memwait", 32'(MEM_WAIT), 0);
    check("async_reset_strobe", 32'(EXEC_STROBE), 0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_uinstr(mk_word(1'($urandom), 1'($urandom), $urandom_range(0, 7),
                         $urandom_range(0, 2047)),
                 $urandom, 4'($urandom), $urandom_range(0, 2), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
# microsequencer

Control-store address sequencer for the ARC microarchitecture. It sits directly upstream of the microinstruction register: it drives the 11-bit control-store ADDRESS, reads back the 41-bit microword, and picks the next address. The choice comes from the microword's COND and JUMP ADDR fields, the PSR flags and the IR. A small FSM enforces a two-phase microcycle, stalls on memory accesses and emits a commit strobe for the datapath.

## Interface
- DATAWIDTH_BUS_ADDRESS, 11, control-store address width
- DATAWIDTH_BUS_WORD, 41, microword width
- DATAWIDTH_BUS_IR, 32, instruction register width
- CLK  in  1  system clock, rising edge
- RESET_InLow  in  1  asynchronous, active-low reset
- MIR_WORD  in  41  current microword, registered by the MIR
- IR  in  32  current instruction
- PSR_NZVC  in  4  condition flags, {N,Z,V,C}
- MEM_ACK  in  1  memory access complete
- ADDRESS  out  11  registered control-store address
- EXEC_STROBE  out  1  current microword commits this cycle (datapath write enable)
- MEM_WAIT  out  1  sequencer is stalled on memory

## Operation
- Microword fields (bit 40 = MSB): A[40:35], AMUX[34], B[33:28], BMUX[27], C[26:21], CMUX[20], RD[19], WR[18], ALU[17:14], COND[13:11], JUMP_ADDR[10:0].
- COND encoding and the resulting next address:
  - 000: ADDRESS+1
  - 001: JUMP_ADDR if N, else ADDRESS+1
  - 010: JUMP_ADDR if Z, else ADDRESS+1
  - 011: JUMP_ADDR if V, else ADDRESS+1
  - 100: JUMP_ADDR if C, else ADDRESS+1
  - 101: JUMP_ADDR if IR[13], else ADDRESS+1
  - 110: JUMP_ADDR unconditionally
  - 111: decode, {1'b1, IR[31:30], IR[24:19], 2'b00}
- Decode examples: ADDCC (op=10, op3=010000) gives 1600; op=00 formats land in the 1024–1279 region.
- ADDRESS+1 is an 11-bit add: 2047+1 wraps to 0, with no flag and no error.
- FSM states:
  - FETCH: ADDRESS is stable and the MIR latches the word at the end of this cycle. Always goes to EXEC next.
  - EXEC: MIR_WORD is valid.
    - If (RD|WR) and !MEM_ACK, go to WAIT and hold ADDRESS.
    - Otherwise load the next address into ADDRESS, pulse EXEC_STROBE and go to FETCH.
  - WAIT: ADDRESS is held and MEM_WAIT=1.
    - When MEM_ACK=1, load the next address, pulse EXEC_STROBE and go to FETCH.
    - Otherwise stay in WAIT.
- The next address is evaluated in the cycle it is loaded, using the PSR_NZVC and IR present in that cycle.
- MEM_ACK is ignored in FETCH, and in EXEC when RD=WR=0.
- RD=WR=1 in the same word is treated as a single access needing one MEM_ACK.
- Reset, at any time including mid-WAIT:
  - ADDRESS=0, state=FETCH, EXEC_STROBE=0, MEM_WAIT=0, all immediately (asynchronous).
  - The first microword executed after reset is address 0.

## Timing
- A microinstruction with no memory access takes 2 cycles (FETCH, EXEC).
- A memory microinstruction takes 2 cycles plus one cycle per cycle that MEM_ACK stays low.
- ADDRESS changes only on the rising edge that ends EXEC or ends a WAIT cycle with MEM_ACK=1.
- EXEC_STROBE is combinational from state and MEM_ACK. It is high for exactly one cycle per microinstruction: the same cycle in which ADDRESS is loaded with its new value at the closing edge.
- MEM_WAIT is registered: high in every WAIT cycle, low otherwise.
- Flag inputs have no internal latching; the datapath must hold PSR_NZVC stable through EXEC/WAIT.

## Structure
- Package microsequencer_pkg holds:
  - microword field bit positions
  - COND encodings (COND_NEXT … COND_DECODE)
  - FSM state encodings (FETCH, EXEC, WAIT)
  - the reset address constant (0)
- Sub-module microsequencer_cbl: purely combinational branch logic, computing next address from COND, JUMP_ADDR, ADDRESS, PSR_NZVC and IR.
- The top level holds only the FSM and the ADDRESS register.

## Test plan
- Reset with RESET_InLow=0 for 3 cycles -> ADDRESS=0, EXEC_STROBE=0, MEM_WAIT=0; after release, the first cycle is FETCH and ADDRESS moves on the second edge.
- Decode: IR op=10, op3=010000, COND=111 -> ADDRESS=1600 after EXEC; EXEC_STROBE pulses once.
- Conditional branch: ADDRESS=8, COND=010, JUMP_ADDR=12.
  - With Z=1 -> ADDRESS=12.
  - With Z=0 -> ADDRESS=9.
  - COND=101 with IR[13]=1 -> ADDRESS=JUMP_ADDR.
- Memory stall: RD=1, MEM_ACK low for 3 cycles then high.
  - ADDRESS is held and MEM_WAIT=1 for 3 cycles.
  - EXEC_STROBE=1 only in the ack cycle; then ADDRESS advances.
- Wrap-around: ADDRESS=2047, COND=000 -> ADDRESS=0.
- Reset asserted during WAIT -> ADDRESS=0, MEM_WAIT=0 immediately, no EXEC_STROBE; restart from FETCH.
